// File: rtl/divider_ctrl.sv
// Sequencing FSM for the shift-subtract divider datapath.
// Drives load / shift / final-adjust strobes and the result handshake.
module divider_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     divisor_zero,
    input  logic                     ack,
    output logic                     w_ctrl,
    output logic                     sll_ctrl,
    output logic                     srl_ctrl,
    output logic                     ready,
    output logic                     busy,
    output logic                     div_by_zero,
    output logic [$clog2(WIDTH)-1:0] iter_count
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_SHIFT  = 3'd2;
    localparam logic [2:0] S_ADJUST = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dbz_q, dbz_d;

    // Next-state, iteration counter and error flag computation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (divisor_zero) begin
                        state_d = S_DONE;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                cnt_d   = '0;
                dbz_d   = 1'b0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (cnt_q == LAST_ITER) begin
                    cnt_d   = '0;
                    state_d = S_ADJUST;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ADJUST: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                // Result is held until the consumer acknowledges it;
                // a new request may ride on the same acknowledge cycle.
                if (ack) begin
                    if (!start) begin
                        state_d = S_IDLE;
                    end else if (divisor_zero) begin
                        state_d = S_DONE;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                dbz_d   = 1'b0;
            end
        endcase
    end

    // State registers with asynchronous reset shared with the datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

    // Moore output decode from the registered state
    always_comb begin
        w_ctrl      = (state_q == S_LOAD);
        sll_ctrl    = (state_q == S_SHIFT);
        srl_ctrl    = (state_q == S_ADJUST);
        ready       = (state_q == S_DONE);
        busy        = (state_q == S_LOAD) ||
                      (state_q == S_SHIFT) ||
                      (state_q == S_ADJUST);
        div_by_zero = dbz_q;
        iter_count  = cnt_q;
    end

endmodule
